// File: rtl/hack_ram_arbiter_if.sv
// rtl/hack_ram_arbiter_if.sv - CPU/video/RAM signal bundle for the Hack data RAM arbiter
// slave = arbiter side, master = requester/RAM side.
interface hack_ram_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [DW-1:0] vid_rdata;
  logic          vid_rvalid;

  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_in;
  logic          ram_load;
  logic [DW-1:0] ram_out;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_out,
    output cpu_ack, cpu_rdata, cpu_rvalid, vid_ack, vid_rdata, vid_rvalid,
    output ram_address, ram_in, ram_load
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_out,
    input  cpu_ack, cpu_rdata, cpu_rvalid, vid_ack, vid_rdata, vid_rvalid,
    input  ram_address, ram_in, ram_load
  );
endinterface

// File: rtl/hack_ram_arbiter.sv
// rtl/hack_ram_arbiter.sv - single-port data RAM arbiter between Hack CPU and video scanout
// Build option CPU_PRIORITY_EN: CPU wins ties, video forced in after MAX_WAIT refused cycles.
module hack_ram_arbiter #(
  parameter int AW = 14,
  parameter int DW = 16
`ifdef CPU_PRIORITY_EN
  , parameter int MAX_WAIT = 8
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  hack_ram_arbiter_if.slave bus
);

  logic          cpu_win;
  logic [AW-1:0] grant_addr;
  logic          cpu_pend;
  logic          vid_pend;
  logic          cpu_rvalid_q;
  logic          vid_rvalid_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] vid_rdata_q;

`ifdef CPU_PRIORITY_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;
  logic          vid_starved;
  assign vid_starved = (wait_cnt == WW'(MAX_WAIT));
`else
  typedef enum logic {GRANT_CPU, GRANT_VID} grant_t;
  grant_t last_grant;
`endif

  // Video only gets the RAM when the CPU is not the winner, so the acks are exclusive.
  always_comb begin
    cpu_win = bus.cpu_req;
    if (bus.cpu_req && bus.vid_req) begin
`ifdef CPU_PRIORITY_EN
      cpu_win = !vid_starved;
`else
      cpu_win = (last_grant == GRANT_VID);
`endif
    end
  end

  assign bus.cpu_ack     = cpu_win;
  assign bus.vid_ack     = bus.vid_req & ~cpu_win;
  assign grant_addr      = bus.vid_ack ? bus.vid_addr : bus.cpu_addr;
  assign bus.ram_address = grant_addr;
  assign bus.ram_in      = bus.cpu_wdata;
  assign bus.ram_load    = bus.cpu_ack & bus.cpu_we;

  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.vid_rdata   = vid_rdata_q;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.vid_rvalid  = vid_rvalid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_pend     <= 1'b0;
      vid_pend     <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vid_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      vid_rdata_q  <= '0;
`ifdef CPU_PRIORITY_EN
      wait_cnt     <= '0;
`else
      last_grant   <= GRANT_VID;
`endif
    end else begin
      // ram_out is valid the cycle after the address was sampled.
      cpu_pend     <= bus.cpu_ack & ~bus.cpu_we;
      vid_pend     <= bus.vid_ack;
      cpu_rvalid_q <= cpu_pend;
      vid_rvalid_q <= vid_pend;
      if (cpu_pend) cpu_rdata_q <= bus.ram_out;
      if (vid_pend) vid_rdata_q <= bus.ram_out;
`ifdef CPU_PRIORITY_EN
      if (bus.vid_ack || !bus.vid_req) wait_cnt <= '0;
      else if (!vid_starved)           wait_cnt <= wait_cnt + 1'b1;
`else
      if (bus.cpu_ack)      last_grant <= GRANT_CPU;
      else if (bus.vid_ack) last_grant <= GRANT_VID;
`endif
    end
  end

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// tb/tb_hack_ram_arbiter.sv - scoreboard bench for hack_ram_arbiter with RAM stub and reference model
module tb_hack_ram_arbiter;
  localparam int AW = 14;
  localparam int DW = 16;
  localparam int MAX_WAIT = 8;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  hack_ram_arbiter_if #(.AW(AW), .DW(DW)) bus();

  hack_ram_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DW-1:0] mem     [1 << AW];
  logic [DW-1:0] ref_mem [1 << AW];
  exp_t cpu_q[$];
  exp_t vid_q[$];

  logic exp_cpu_ack;
  logic exp_vid_ack;
  logic ref_last_vid;
  int   ref_wait;
  logic [DW-1:0] hold_cpu;
  logic [DW-1:0] hold_vid;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'(i * 40503) ^ 16'h5a5a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronous-read single-port RAM stub.
  always @(posedge clk) begin
    if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
    bus.ram_out <= mem[bus.ram_address];
  end

  // Reference model: decides who should win this cycle and what each read must return.
  always @(negedge clk) begin
    logic g_cpu;
    logic g_vid;
    exp_t e;
    if (!reset_n) begin
      cpu_q.delete();
      vid_q.delete();
      ref_last_vid = 1'b1;
      ref_wait     = 0;
      exp_cpu_ack  = 1'b0;
      exp_vid_ack  = 1'b0;
    end else begin
      if (bus.cpu_req && bus.vid_req) begin
`ifdef CPU_PRIORITY_EN
        g_cpu = (ref_wait < MAX_WAIT);
`else
        g_cpu = ref_last_vid;
`endif
      end else begin
        g_cpu = bus.cpu_req;
      end
      g_vid = bus.vid_req && !g_cpu;
      chk("cpu_ack", 32'(bus.cpu_ack), 32'(g_cpu));
      chk("vid_ack", 32'(bus.vid_ack), 32'(g_vid));
      chk("ram_load", 32'(bus.ram_load), 32'(g_cpu && bus.cpu_we));
      chk("ram_address", 32'(bus.ram_address), 32'(g_vid ? bus.vid_addr : bus.cpu_addr));
      if (g_cpu && bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
      if (g_cpu && !bus.cpu_we) begin
        e.cyc = cyc + 2; e.data = ref_mem[bus.cpu_addr]; cpu_q.push_back(e);
      end
      if (g_vid) begin
        e.cyc = cyc + 2; e.data = ref_mem[bus.vid_addr]; vid_q.push_back(e);
      end
      if (g_cpu || g_vid) ref_last_vid = g_vid;
      if (g_vid || !bus.vid_req) ref_wait = 0;
      else if (ref_wait < MAX_WAIT) ref_wait++;
      exp_cpu_ack = g_cpu;
      exp_vid_ack = g_vid;
    end
  end

  // Monitor: pops the scoreboard whenever a result is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
      chk("rst_vid_rvalid", 32'(bus.vid_rvalid), 0);
      chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
      chk("rst_vid_rdata", 32'(bus.vid_rdata), 0);
      hold_cpu = '0;
      hold_vid = '0;
    end else begin
      if (bus.cpu_rvalid) begin
        if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 1, 0);
        else begin
          e = cpu_q.pop_front();
          chk("cpu_rvalid_cycle", 32'(cyc), 32'(e.cyc));
          chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e.data));
          hold_cpu = e.data;
        end
      end else begin
        chk("cpu_rdata_hold", 32'(bus.cpu_rdata), 32'(hold_cpu));
        if (cpu_q.size() > 0 && cpu_q[0].cyc <= cyc) begin
          chk("cpu_rvalid_missing", 0, 1);
          void'(cpu_q.pop_front());
        end
      end
      if (bus.vid_rvalid) begin
        if (vid_q.size() == 0) chk("vid_rvalid_unexpected", 1, 0);
        else begin
          e = vid_q.pop_front();
          chk("vid_rvalid_cycle", 32'(cyc), 32'(e.cyc));
          chk("vid_rdata", 32'(bus.vid_rdata), 32'(e.data));
          hold_vid = e.data;
        end
      end else begin
        chk("vid_rdata_hold", 32'(bus.vid_rdata), 32'(hold_vid));
        if (vid_q.size() > 0 && vid_q[0].cyc <= cyc) begin
          chk("vid_rvalid_missing", 0, 1);
          void'(vid_q.pop_front());
        end
      end
    end
  end

  // Requests stay up until acked, then a fresh random transaction (or idle) is chosen.
  task automatic step(input int pc, input int pv, input int pw);
    @(posedge clk); #1;
    if (!bus.cpu_req || exp_cpu_ack) begin
      bus.cpu_req   = ($urandom_range(99) < pc);
      bus.cpu_we    = ($urandom_range(99) < pw);
      bus.cpu_addr  = AW'($urandom_range(31));
      bus.cpu_wdata = DW'($urandom);
    end
    if (!bus.vid_req || exp_vid_ack) begin
      bus.vid_req  = ($urandom_range(99) < pv);
      bus.vid_addr = AW'($urandom_range(31));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nv;
    int k;
    logic rv;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    bus.ram_out   = '0;
    reset_n       = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Both requesters held: round-robin alternates, priority mode lets video in every 9th cycle.
    nv = 0;
    for (int i = 0; i < 18; i++) begin
      step(100, 100, 30);
      @(negedge clk);
      if (bus.vid_ack) nv++;
    end
`ifdef CPU_PRIORITY_EN
    chk("contested_vid_grants", 32'(nv), 2);
`else
    chk("contested_vid_grants", 32'(nv), 9);
`endif

    // Write then immediate read-back of the same word.
    @(posedge clk); #1;
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0010; bus.cpu_wdata = 16'h1234;
    @(posedge clk); #1 bus.cpu_we = 1'b0;
    @(posedge clk); #1 bus.cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wr_rd_data", 32'(bus.cpu_rdata), 32'h1234);

    // Video-only burst 0x2000..0x2003.
    @(posedge clk); #1;
    bus.vid_req = 1'b1; bus.vid_addr = 14'h2000;
    k = 0;
    for (int i = 0; i < 20 && k < 4; i++) begin
      @(negedge clk);
      if (bus.vid_ack) k++;
      @(posedge clk); #1;
      if (k == 4) bus.vid_req = 1'b0;
      else bus.vid_addr = AW'(14'h2000 + k);
    end
    chk("vid_burst_grants", 32'(k), 4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("vid_burst_last_data", 32'(bus.vid_rdata), 32'(init_word(14'h2003)));

    // Idle: no loads, no results, read data holds.
    rv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rv = rv | bus.cpu_rvalid | bus.vid_rvalid | bus.ram_load;
    end
    chk("idle_quiet", 32'(rv), 0);
    chk("idle_cpu_hold", 32'(bus.cpu_rdata), 32'h1234);

    // Reset one cycle after a CPU read grant drops the read.
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0005;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    reset_n = 1'b0;
    rv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rv = rv | bus.cpu_rvalid | bus.vid_rvalid;
    end
    chk("reset_drops_read", 32'(rv), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0007;
    bus.vid_req = 1'b1; bus.vid_addr = 14'h0009;
    @(negedge clk);
    chk("post_reset_tie", {30'd0, bus.cpu_ack, bus.vid_ack}, 32'b10);

    // Randomised traffic with address collisions.
    repeat (3000) step(60, 50, 40);

    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    bus.vid_req = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_cpu", 32'(cpu_q.size()), 0);
    chk("drain_vid", 32'(vid_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
